// File: rtl/sram_1rw_22x64_arbiter.sv
// ---------------------------------------------------------------------------
// sram_1rw_22x64_arbiter
//
// Two-requester round-robin front end for a single-port (1RW) SRAM macro
// with NUM_WORDS implemented words. One request is in flight at a time. Each
// request takes a fixed three-cycle trip: IDLE (accept), ACCESS (SRAM
// enabled), RESP (read data settles). A one-cycle response pulse follows in
// the next IDLE cycle. Addresses at or above NUM_WORDS never reach the SRAM.
// Instead they return an error response with zero data.
//
// Ports
//   clk0        : single clock; all logic runs on the rising edge
//   rst0        : synchronous, active-high reset
//   req_valid   : [1:0] request valid, bit i = requester i
//   req_ready   : [1:0] one-hot grant; a bit is high only in IDLE for the winner
//   req_we      : [1:0] per-requester write enable (1 = write)
//   req_addr    : [2*ADDR_WIDTH-1:0] per-requester address slices
//   req_wdata   : [2*DATA_WIDTH-1:0] per-requester write data slices
//   rsp_valid   : [1:0] one-cycle response pulse to the requester that was served
//   rsp_err     : out-of-range flag, qualified by rsp_valid
//   rsp_rdata   : read data (zero for writes and errors), qualified by rsp_valid
//   sram_csb0   : registered active-low chip select
//   sram_web0   : registered active-low write enable
//   sram_addr0  : registered SRAM address
//   sram_din0   : registered SRAM write data
//   sram_dout0  : SRAM read data, valid one cycle after the SRAM samples
// ---------------------------------------------------------------------------
module sram_1rw_22x64_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WORDS  = 22
) (
    input  logic                    clk0,
    input  logic                    rst0,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic                    rsp_err,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    input  logic [DATA_WIDTH-1:0]   sram_dout0
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // One extra bit lets the range check handle NUM_WORDS == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] LIMIT = NUM_WORDS[ADDR_WIDTH:0];

    logic [1:0]            state;
    logic                  prio;
    logic                  op_id;
    logic                  op_we;
    logic                  op_err;

    logic                  grant_id;
    logic                  accept;
    logic                  in_range;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    // Arbitration. A lone requester always wins. Under contention, prio
    // names the requester that was not served by the most recent accept.
    always_comb begin
        grant_id = 1'b0;
        case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = prio;
            default: grant_id = 1'b0;
        endcase
        accept    = (state == ST_IDLE) && !rst0 && (req_valid != 2'b00);
        req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
        win_we    = grant_id ? req_we[1] : req_we[0];
        win_addr  = grant_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                             : req_addr[ADDR_WIDTH-1:0];
        win_wdata = grant_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                             : req_wdata[DATA_WIDTH-1:0];
        in_range  = {1'b0, win_addr} < LIMIT;
    end

    // Sequencer. The winner's request is captured at accept, so later changes
    // on the requester inputs cannot disturb the operation in flight. The
    // response pulse is produced only by the RESP->IDLE edge. A reset during
    // ACCESS or RESP therefore drops the operation silently.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state      <= ST_IDLE;
            prio       <= 1'b0;
            op_id      <= 1'b0;
            op_we      <= 1'b0;
            op_err     <= 1'b0;
            sram_csb0  <= 1'b1;
            sram_web0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            rsp_valid  <= 2'b00;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_ACCESS;
                        op_id  <= grant_id;
                        op_we  <= win_we;
                        op_err <= !in_range;
                        prio   <= ~grant_id;
                        if (in_range) begin
                            sram_csb0  <= 1'b0;
                            sram_web0  <= ~win_we;
                            sram_addr0 <= win_addr;
                            sram_din0  <= win_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    state     <= ST_RESP;
                    sram_csb0 <= 1'b1;
                    sram_web0 <= 1'b1;
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= op_id ? 2'b10 : 2'b01;
                    rsp_err   <= op_err;
                    rsp_rdata <= (op_err || op_we) ? '0 : sram_dout0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_1rw_22x64_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_1rw_22x64_arbiter
//
// Self-checking bench for sram_1rw_22x64_arbiter. A small behavioural 1RW
// SRAM with registered read data sits on the macro-side ports. Expected
// results come from a transaction-level reference model: an array holding
// the expected word contents plus a "preferred requester" variable for the
// round-robin rule.
// ---------------------------------------------------------------------------
module tb_sram_1rw_22x64_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NW = 22;

    logic            clk0;
    logic            rst0;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic            sram_csb0;
    logic            sram_web0;
    logic [AW-1:0]   sram_addr0;
    logic [DW-1:0]   sram_din0;
    logic [DW-1:0]   sram_dout0;

    int n_checks;
    int n_fail;

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            rr_pref;

    // Behavioural SRAM macro.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];

    sram_1rw_22x64_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_WORDS (NW)
    ) dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .sram_csb0 (sram_csb0),
        .sram_web0 (sram_web0),
        .sram_addr0(sram_addr0),
        .sram_din0 (sram_din0),
        .sram_dout0(sram_dout0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // The SRAM samples on the rising edge while enabled. Read data is
    // registered, so it is valid for the whole following cycle.
    always @(posedge clk0) begin
        if (!sram_csb0) begin
            if (!sram_web0) sram_mem[sram_addr0] <= sram_din0;
            else            sram_dout0 <= sram_mem[sram_addr0];
        end
    end

    // Reference model for one accepted request. A lone valid requester wins.
    // Under contention the preferred requester wins. The requester just
    // served becomes non-preferred.
    task automatic model_predict(input logic [1:0] v, input logic [1:0] we,
                                 input logic [2*AW-1:0] addr, input logic [2*DW-1:0] wdata,
                                 output logic [1:0] exp_rv, output logic exp_err,
                                 output logic [DW-1:0] exp_rdata);
        int w;
        int a;
        logic wr;
        logic [DW-1:0] d;
        if (v == 2'b01)      w = 0;
        else if (v == 2'b10) w = 1;
        else                 w = rr_pref;
        a  = int'(addr[w*AW +: AW]);
        wr = we[w];
        d  = wdata[w*DW +: DW];
        exp_rv    = (w == 0) ? 2'b01 : 2'b10;
        exp_err   = (a >= NW);
        exp_rdata = (exp_err || wr) ? '0 : ref_mem[a];
        if (!exp_err && wr) ref_mem[a] = d;
        rr_pref = 1 - w;
    endtask

    // Drive one request and collect what the DUT did with it. This task only
    // observes; the caller decides what was expected.
    task automatic transact(input logic [1:0] v, input logic [1:0] we,
                            input logic [2*AW-1:0] addr, input logic [2*DW-1:0] wdata,
                            output logic [1:0] ready_obs, output int lat,
                            output logic [1:0] rv, output logic err,
                            output logic [DW-1:0] rdata, output bit csb_low,
                            output bit timeout);
        int waited;
        timeout = 0;
        csb_low = 0;
        lat     = 0;
        rv      = 2'b00;
        err     = 1'b0;
        rdata   = '0;
        @(negedge clk0);
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        waited = 0;
        while (req_ready == 2'b00 && waited < 10) begin
            @(negedge clk0);
            #1;
            waited++;
        end
        ready_obs = req_ready;
        if (req_ready == 2'b00) begin
            timeout   = 1;
            req_valid = 2'b00;
            return;
        end
        @(posedge clk0);
        #1;
        // Scramble the inputs after accept; the operation must not notice.
        req_valid = 2'b00;
        req_we    = 2'($urandom);
        req_addr  = 10'($urandom);
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk0);
            lat = k;
            if (sram_csb0 == 1'b0) csb_low = 1;
            if (rsp_valid != 2'b00) break;
        end
        if (rsp_valid == 2'b00) timeout = 1;
        rv    = rsp_valid;
        err   = rsp_err;
        rdata = rsp_rdata;
    endtask

    // Plain reset pulse, used to restart the round-robin history.
    task automatic do_reset();
        @(negedge clk0);
        rst0      = 1'b1;
        req_valid = 2'b00;
        @(negedge clk0);
        @(negedge clk0);
        rst0    = 1'b0;
        rr_pref = 0;
    endtask

    task automatic test_reset();
        rst0      = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {5'd2, 5'd1};
        req_wdata = '0;
        repeat (3) @(negedge clk0);
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("[TB] FAIL reset_ready: got %b, expected 00", req_ready);
        end
        n_checks++;
        if (sram_csb0 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_csb: got %b, expected 1", sram_csb0);
        end
        n_checks++;
        if (sram_web0 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_web: got %b, expected 1", sram_web0);
        end
        n_checks++;
        if (sram_addr0 !== '0) begin
            n_fail++; $display("[TB] FAIL reset_addr: got %h, expected 0", sram_addr0);
        end
        n_checks++;
        if (sram_din0 !== '0) begin
            n_fail++; $display("[TB] FAIL reset_din: got %h, expected 0", sram_din0);
        end
        n_checks++;
        if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_rsp: got valid=%b err=%b rdata=%h, expected 0/0/0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        req_valid = 2'b00;
        rst0      = 1'b0;
        rr_pref   = 0;
    endtask

    task automatic test_write_read();
        logic [1:0] rdy, rv, erv;
        logic err, eerr;
        logic [DW-1:0] rd, erd;
        int lat;
        bit csb_low, to;
        for (int i = 0; i < 2; i++) begin
            logic [1:0] we;
            we = (i == 0) ? 2'b01 : 2'b00;
            model_predict(2'b01, we, {5'd0, 5'd5}, {64'd0, 64'hDEADBEEF_0123_4567}, erv, eerr, erd);
            transact(2'b01, we, {5'd0, 5'd5}, {64'd0, 64'hDEADBEEF_0123_4567},
                     rdy, lat, rv, err, rd, csb_low, to);
            n_checks++;
            if (to || rdy !== 2'b01 || lat != 3) begin
                n_fail++;
                $display("[TB] FAIL wr_rd_timing[%0d]: got ready=%b lat=%0d timeout=%0d, expected 01/3/0",
                         i, rdy, lat, to);
            end
            n_checks++;
            if (rv !== erv || err !== eerr || rd !== erd || !csb_low) begin
                n_fail++;
                $display("[TB] FAIL wr_rd_rsp[%0d]: got rv=%b err=%b rdata=%h csb_low=%0d, expected %b/%b/%h/1",
                         i, rv, err, rd, csb_low, erv, eerr, erd);
            end
        end
        n_checks++;
        if (rd !== 64'hDEADBEEF01234567) begin
            n_fail++; $display("[TB] FAIL wr_rd_value: got %h, expected deadbeef01234567", rd);
        end
    endtask

    task automatic test_contention();
        logic [1:0] rdy, rv, erv, want;
        logic err, eerr;
        logic [DW-1:0] rd, erd;
        int lat;
        bit csb_low, to;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            model_predict(2'b11, 2'b00, {5'd2, 5'd1}, '0, erv, eerr, erd);
            transact(2'b11, 2'b00, {5'd2, 5'd1}, '0, rdy, lat, rv, err, rd, csb_low, to);
            n_checks++;
            if (to || rdy !== want || rv !== want) begin
                n_fail++;
                $display("[TB] FAIL contention_grant[%0d]: got ready=%b rv=%b timeout=%0d, expected %b",
                         i, rdy, rv, to, want);
            end
            n_checks++;
            if (rv !== erv || err !== 1'b0 || rd !== erd) begin
                n_fail++;
                $display("[TB] FAIL contention_rsp[%0d]: got rv=%b err=%b rdata=%h, expected %b/0/%h",
                         i, rv, err, rd, erv, erd);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] rdy, rv, erv;
        logic err, eerr;
        logic [DW-1:0] rd, erd;
        int lat;
        bit csb_low, to;
        logic [AW-1:0] addrs [2];
        addrs[0] = 5'd22;
        addrs[1] = 5'd31;
        for (int i = 0; i < 2; i++) begin
            model_predict(2'b10, 2'b00, {addrs[i], 5'd0}, '0, erv, eerr, erd);
            transact(2'b10, 2'b00, {addrs[i], 5'd0}, '0, rdy, lat, rv, err, rd, csb_low, to);
            n_checks++;
            if (to || csb_low || lat != 3) begin
                n_fail++;
                $display("[TB] FAIL oor_access[%0d]: got csb_low=%0d lat=%0d timeout=%0d, expected 0/3/0",
                         i, csb_low, lat, to);
            end
            n_checks++;
            if (rv !== 2'b10 || err !== 1'b1 || rd !== '0 || eerr !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL oor_rsp[%0d]: got rv=%b err=%b rdata=%h, expected 10/1/0",
                         i, rv, err, rd);
            end
        end
    endtask

    task automatic test_boundary();
        logic [1:0] rdy, rv, erv;
        logic err, eerr;
        logic [DW-1:0] rd, erd;
        int lat;
        bit csb_low, to;
        for (int i = 0; i < 2; i++) begin
            logic [1:0] we;
            we = (i == 0) ? 2'b01 : 2'b00;
            model_predict(2'b01, we, {5'd0, 5'd21}, {64'd0, {DW{1'b1}}}, erv, eerr, erd);
            transact(2'b01, we, {5'd0, 5'd21}, {64'd0, {DW{1'b1}}}, rdy, lat, rv, err, rd, csb_low, to);
            n_checks++;
            if (to || rv !== erv || err !== eerr || rd !== erd || !csb_low) begin
                n_fail++;
                $display("[TB] FAIL boundary[%0d]: got rv=%b err=%b rdata=%h csb_low=%0d, expected %b/%b/%h/1",
                         i, rv, err, rd, csb_low, erv, eerr, erd);
            end
        end
        n_checks++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("[TB] FAIL boundary_value: got %h, expected ffffffffffffffff", rd);
        end
    endtask

    task automatic test_random();
        logic [1:0] rdy, rv, erv, v, we;
        logic err, eerr;
        logic [DW-1:0] rd, erd;
        logic [2*AW-1:0] addr;
        logic [2*DW-1:0] wdata;
        int lat;
        bit csb_low, to;
        // Fill every implemented word so later random reads are all defined.
        for (int a = 0; a < NW; a++) begin
            v     = (a % 2 == 0) ? 2'b01 : 2'b10;
            addr  = {5'(a), 5'(a)};
            wdata = {$urandom, $urandom, $urandom, $urandom};
            model_predict(v, 2'b11, addr, wdata, erv, eerr, erd);
            transact(v, 2'b11, addr, wdata, rdy, lat, rv, err, rd, csb_low, to);
            n_checks++;
            if (to || rv !== erv || err !== 1'b0 || rd !== '0) begin
                n_fail++;
                $display("[TB] FAIL preload[%0d]: got rv=%b err=%b rdata=%h timeout=%0d, expected %b/0/0",
                         a, rv, err, rd, to, erv);
            end
        end
        for (int i = 0; i < 40; i++) begin
            v     = 2'($urandom_range(1, 3));
            we    = 2'($urandom);
            addr  = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
            wdata = {$urandom, $urandom, $urandom, $urandom};
            model_predict(v, we, addr, wdata, erv, eerr, erd);
            transact(v, we, addr, wdata, rdy, lat, rv, err, rd, csb_low, to);
            n_checks++;
            if (to || rdy !== erv || lat != 3 || csb_low !== !eerr) begin
                n_fail++;
                $display("[TB] FAIL random_grant[%0d]: got ready=%b lat=%0d csb_low=%0d timeout=%0d, expected %b/3/%0d",
                         i, rdy, lat, csb_low, to, erv, !eerr);
            end
            n_checks++;
            if (rv !== erv || err !== eerr || rd !== erd) begin
                n_fail++;
                $display("[TB] FAIL random_rsp[%0d]: got rv=%b err=%b rdata=%h, expected %b/%b/%h",
                         i, rv, err, rd, erv, eerr, erd);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [1:0] rdy, rv, erv;
        logic err, eerr;
        logic [DW-1:0] rd, erd;
        int lat;
        bit csb_low, to;
        @(negedge clk0);
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {5'd0, 5'd5};
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("[TB] FAIL midop_accept: got ready=%b, expected 01", req_ready);
        end
        @(posedge clk0);
        #1 req_valid = 2'b00;
        @(negedge clk0);
        @(negedge clk0);
        rst0 = 1'b1;
        @(negedge clk0);
        n_checks++;
        if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
            n_fail++;
            $display("[TB] FAIL midop_rsp: got valid=%b err=%b rdata=%h, expected 00/0/0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        n_checks++;
        if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || sram_addr0 !== '0 || sram_din0 !== '0) begin
            n_fail++;
            $display("[TB] FAIL midop_sram: got csb=%b web=%b addr=%h din=%h, expected 1/1/0/0",
                     sram_csb0, sram_web0, sram_addr0, sram_din0);
        end
        rst0      = 1'b0;
        rr_pref   = 0;
        req_valid = 2'b10;
        req_addr  = {5'd2, 5'd0};
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("[TB] FAIL midop_regrant: got ready=%b, expected 10", req_ready);
        end
        req_valid = 2'b00;
        model_predict(2'b10, 2'b00, {5'd2, 5'd0}, '0, erv, eerr, erd);
        transact(2'b10, 2'b00, {5'd2, 5'd0}, '0, rdy, lat, rv, err, rd, csb_low, to);
        n_checks++;
        if (to || rdy !== 2'b10 || rv !== erv || err !== eerr || rd !== erd) begin
            n_fail++;
            $display("[TB] FAIL midop_p1: got ready=%b rv=%b err=%b rdata=%h, expected 10/%b/%b/%h",
                     rdy, rv, err, rd, erv, eerr, erd);
        end
    endtask

    task automatic test_back_to_back();
        int acc_cycles [$];
        logic [1:0] rv_at [0:14];
        logic [DW-1:0] rd_at [0:14];
        @(negedge clk0);
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {5'd0, 5'd7};
        for (int c = 0; c < 15; c++) begin
            #1;
            if (req_ready == 2'b01) acc_cycles.push_back(c);
            rv_at[c] = rsp_valid;
            rd_at[c] = rsp_rdata;
            @(negedge clk0);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk0);
        rr_pref = 1;
        n_checks++;
        if (acc_cycles.size() != 5) begin
            n_fail++; $display("[TB] FAIL b2b_count: got %0d accepts, expected 5", acc_cycles.size());
        end
        for (int i = 1; i < acc_cycles.size(); i++) begin
            n_checks++;
            if (acc_cycles[i] - acc_cycles[i-1] != 3) begin
                n_fail++;
                $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles, expected 3",
                         i, acc_cycles[i] - acc_cycles[i-1]);
            end
            n_checks++;
            if (rv_at[acc_cycles[i]] !== 2'b01 || rd_at[acc_cycles[i]] !== ref_mem[7]) begin
                n_fail++;
                $display("[TB] FAIL b2b_overlap[%0d]: got rv=%b rdata=%h, expected 01/%h",
                         i, rv_at[acc_cycles[i]], rd_at[acc_cycles[i]], ref_mem[7]);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rr_pref   = 0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rst0      = 1'b1;
        sram_dout0 = '0;
        test_reset();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_boundary();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
